// File: rtl/video_pkg.sv
// Shared types and default sizing for the video pixel feeder.
package video_pkg;

    localparam int unsigned VID_DW      = 24;
    localparam int unsigned VID_AW      = 9;
    localparam int unsigned VID_PREFILL = 256;

    // Frame-alignment states of the feeder
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ALIGN = 2'd1,
        ST_ARMED = 2'd2,
        ST_RUN   = 2'd3
    } vid_state_t;

endpackage

// File: rtl/video_sync_fifo.sv
// First-word-fall-through synchronous FIFO with flush, level, full and empty.
module video_sync_fifo #(
    parameter int unsigned W  = 25,
    parameter int unsigned AW = 9
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_flush,
    input  logic          i_push,
    input  logic [W-1:0]  i_wr_data,
    input  logic          i_pop,
    output logic [W-1:0]  o_rd_data,
    output logic          o_full,
    output logic          o_empty,
    output logic [AW:0]   o_level
);

    localparam int unsigned DEPTH = 1 << AW;

    logic [W-1:0] r_mem [DEPTH];
    logic [AW:0]  r_wr_ptr;
    logic [AW:0]  r_rd_ptr;
    logic         w_full;
    logic         w_empty;
    logic         w_do_pop;
    logic         w_do_push;

    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_pop  = i_pop && !w_empty;
    // A full FIFO still takes a word when the head leaves in the same cycle
    assign w_do_push = i_push && (!w_full || w_do_pop);

    // Pointer update; flush wins over any same-cycle push or pop
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Storage write, suppressed while flushing
    always_ff @(posedge clk) begin
        if (w_do_push && !i_flush) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
        end
    end

    assign o_rd_data = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
    assign o_full    = w_full;
    assign o_empty   = w_empty;
    assign o_level   = r_wr_ptr - r_rd_ptr;

endmodule

// File: rtl/video_pixel_feeder.sv
// Pixel feeder: buffers the fetcher stream and starts output on a frame boundary.
module video_pixel_feeder
    import video_pkg::*;
#(
    parameter int unsigned DW      = VID_DW,
    parameter int unsigned AW      = VID_AW,
    parameter int unsigned PREFILL = VID_PREFILL
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ctrl_ven,
    input  logic [DW-1:0] wr_data,
    input  logic          wr_sof,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic          pix_ena,
    input  logic          eov,
    input  logic          load_ready,
    output logic          load_valid,
    output logic [DW-1:0] load_data,
    output logic [AW:0]   level,
    output logic          underrun,
    output logic          misalign,
    input  logic          err_clr
);

    localparam logic [AW:0] PREFILL_LVL = PREFILL[AW:0];

    vid_state_t  r_state;
    vid_state_t  w_state_nxt;
    logic        r_first_pix;
    logic        r_underrun;
    logic        r_misalign;

    logic        w_consume;
    logic        w_flush;
    logic        w_push;
    logic        w_pop;
    logic        w_set_under;
    logic        w_set_mis;
    logic        w_wr_ready;
    logic        w_load_valid;
    logic [DW:0] w_head;
    logic        w_full;
    logic        w_empty;
    logic [AW:0] w_level;

    assign w_consume = pix_ena && load_ready;

    video_sync_fifo #(
        .W  (DW + 1),
        .AW (AW)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .i_flush   (w_flush),
        .i_push    (w_push),
        .i_wr_data ({wr_sof, wr_data}),
        .i_pop     (w_pop),
        .o_rd_data (w_head),
        .o_full    (w_full),
        .o_empty   (w_empty),
        .o_level   (w_level)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next state, FIFO control, handshake gating and error detection
    always_comb begin
        w_state_nxt  = r_state;
        w_flush      = 1'b0;
        w_push       = 1'b0;
        w_pop        = 1'b0;
        w_set_under  = 1'b0;
        w_set_mis    = 1'b0;
        w_wr_ready   = 1'b1;
        w_load_valid = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_flush = 1'b1;
                if (ctrl_ven) w_state_nxt = ST_ALIGN;
            end
            ST_ALIGN: begin
                if (wr_sof) begin
                    w_wr_ready = !w_full;
                    if (wr_valid && !w_full) begin
                        w_push      = 1'b1;
                        w_state_nxt = ST_ARMED;
                    end
                end
            end
            ST_ARMED: begin
                w_wr_ready = !w_full;
                w_push     = wr_valid && !w_full;
                if (pix_ena && eov && (w_level >= PREFILL_LVL)) w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                w_load_valid = !w_empty;
                if (w_consume) begin
                    if (w_empty) begin
                        w_set_under = 1'b1;
                        w_flush     = 1'b1;
                        w_state_nxt = ST_ALIGN;
                    end else begin
                        w_pop = 1'b1;
                        if (w_head[DW] && !r_first_pix) begin
                            w_set_mis   = 1'b1;
                            w_flush     = 1'b1;
                            w_state_nxt = ST_ALIGN;
                        end
                    end
                end
                w_wr_ready = !w_full || w_pop;
                w_push     = wr_valid && w_wr_ready;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        if (!ctrl_ven) begin
            w_state_nxt = ST_IDLE;
            w_flush     = 1'b1;
            w_set_under = 1'b0;
            w_set_mis   = 1'b0;
        end
    end

    // first_pix: set on RUN entry, cleared by the first pop
    always_ff @(posedge clk) begin
        if (rst)                                                r_first_pix <= 1'b0;
        else if (r_state == ST_ARMED && w_state_nxt == ST_RUN) r_first_pix <= 1'b1;
        else if (w_pop)                                         r_first_pix <= 1'b0;
    end

    // Sticky error flags; a same-cycle set beats err_clr
    always_ff @(posedge clk) begin
        if (rst) begin
            r_underrun <= 1'b0;
            r_misalign <= 1'b0;
        end else begin
            if (w_set_under)  r_underrun <= 1'b1;
            else if (err_clr) r_underrun <= 1'b0;
            if (w_set_mis)    r_misalign <= 1'b1;
            else if (err_clr) r_misalign <= 1'b0;
        end
    end

    assign wr_ready   = w_wr_ready;
    assign load_valid = w_load_valid;
    assign load_data  = w_head[DW-1:0];
    assign level      = w_level;
    assign underrun   = r_underrun;
    assign misalign   = r_misalign;

endmodule
